// File: rtl/bus_xfer_ctrl.sv
// Bus-master sequencer for the shared tri-state register bus.
// Runs one register-to-register (or immediate-to-register) transfer at a time.
// Each transfer drives the bus for one settle cycle and then strobes the
// destination's write enable for one cycle.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | ready for a request, all strobes low
// DRIVE | source (register or immediate) drives the bus, bus settles
// WRITE | source still drives, destination write enable high
module bus_xfer_ctrl #(
  parameter int N_REGS = 8,
  parameter int IDX_W  = 3,
  parameter int WIDTH  = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [IDX_W-1:0]  req_src,
  input  logic [IDX_W-1:0]  req_dst,
  input  logic              req_imm_en,
  input  logic [WIDTH-1:0]  req_imm,
  output logic [N_REGS-1:0] out_en,
  output logic [N_REGS-1:0] write_en,
  output logic              bus_oe,
  output logic [WIDTH-1:0]  bus_out,
  input  logic [WIDTH-1:0]  bus_in,
  output logic [WIDTH-1:0]  last_data,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, DRIVE, WRITE} state_t;

  // One bit wider than the index so N_REGS = 2**IDX_W still compares correctly.
  localparam logic [IDX_W:0]    IDX_LIM = (IDX_W + 1)'(N_REGS);
  localparam logic [N_REGS-1:0] ONE     = N_REGS'(1);

  state_t           state;
  logic [IDX_W-1:0] dst_q;
  logic             dst_ok;
  logic             src_ok;
  logic             legal;

  // Range check of the incoming request; the source index does not matter
  // when the immediate drives the bus.
  always_comb begin
    dst_ok = ({1'b0, req_dst} < IDX_LIM);
    src_ok = ({1'b0, req_src} < IDX_LIM);
    legal  = dst_ok && (req_imm_en || src_ok);
  end

  // Transfer sequencer; every output is a register so strobes never glitch
  // from the request inputs. Drive strobes are decided at acceptance and
  // held, so request fields are never looked at again.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      dst_q     <= '0;
      req_ready <= 1'b1;
      out_en    <= '0;
      write_en  <= '0;
      bus_oe    <= 1'b0;
      bus_out   <= '0;
      last_data <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (legal) begin
              state     <= DRIVE;
              req_ready <= 1'b0;
              dst_q     <= req_dst;
              if (req_imm_en) begin
                bus_oe  <= 1'b1;
                bus_out <= req_imm;
              end else begin
                out_en  <= ONE << req_src;
              end
            end else begin
              err <= 1'b1;
            end
          end
        end
        DRIVE: begin
          state    <= WRITE;
          write_en <= ONE << dst_q;
        end
        WRITE: begin
          state     <= IDLE;
          out_en    <= '0;
          write_en  <= '0;
          bus_oe    <= 1'b0;
          bus_out   <= '0;
          last_data <= bus_in;
          done      <= 1'b1;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          out_en    <= '0;
          write_en  <= '0;
          bus_oe    <= 1'b0;
          bus_out   <= '0;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Self-checking bench for bus_xfer_ctrl with a six-register bus bank model.
module tb_bus_xfer_ctrl;

  localparam int NR = 6;

  logic          clock;
  logic          reset_n;
  logic          req_valid;
  logic          req_ready;
  logic [2:0]    req_src;
  logic [2:0]    req_dst;
  logic          req_imm_en;
  logic [7:0]    req_imm;
  logic [NR-1:0] out_en;
  logic [NR-1:0] write_en;
  logic          bus_oe;
  logic [7:0]    bus_out;
  logic [7:0]    bus_in;
  logic [7:0]    last_data;
  logic          done;
  logic          err;

  logic [7:0]    bank [NR];
  int            checks = 0;
  int            errors = 0;
  logic          prev_drive;
  logic          prev_we;

  task automatic chk(input string nm, input logic ok);
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $display("FAIL %s", nm);
    end
  endtask

  bus_xfer_ctrl #(.N_REGS(NR), .IDX_W(3), .WIDTH(8)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_src    (req_src),
    .req_dst    (req_dst),
    .req_imm_en (req_imm_en),
    .req_imm    (req_imm),
    .out_en     (out_en),
    .write_en   (write_en),
    .bus_oe     (bus_oe),
    .bus_out    (bus_out),
    .bus_in     (bus_in),
    .last_data  (last_data),
    .done       (done),
    .err        (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Resolved bus: whichever source is enabled drives it.
  always_comb begin
    bus_in = 8'h00;
    if (bus_oe) bus_in = bus_out;
    for (int i = 0; i < NR; i++)
      if (out_en[i]) bus_in = bank[i];
  end

  // Bus registers latch on their write enable.
  always @(posedge clock) begin
    for (int i = 0; i < NR; i++)
      if (write_en[i]) bank[i] <= bus_in;
  end

  // Per-cycle strobe invariants.
  always @(negedge clock) begin
    if (!reset_n) begin
      prev_drive = 1'b0;
      prev_we    = 1'b0;
    end else begin
      chk("inv_out_en_onehot0", $onehot0(out_en) === 1'b1);
      chk("inv_write_en_onehot0", $onehot0(write_en) === 1'b1);
      chk("inv_no_contention", (bus_oe && (|out_en)) === 1'b0);
      if (req_ready) begin
        chk("inv_idle_strobes", {out_en, write_en, bus_oe} === 13'h0);
      end
      if (|write_en) begin
        chk("inv_we_after_drive", {prev_drive, prev_we} === 2'b10);
      end
      prev_drive = bus_oe || (|out_en);
      prev_we    = |write_en;
    end
  end

  typedef struct {
    logic [2:0]    src;
    logic [2:0]    dst;
    logic          imm_en;
    logic [7:0]    imm;
    logic          exp_err;
    logic [NR-1:0] exp_out_en;
    logic [NR-1:0] exp_we;
    logic [7:0]    exp_last;
  } vec_t;

  vec_t vt [9];

  task automatic do_xfer(input vec_t v);
    logic [7:0] exp_bo;
    exp_bo = v.imm_en ? v.imm : 8'h00;
    @(negedge clock);
    req_src    = v.src;
    req_dst    = v.dst;
    req_imm_en = v.imm_en;
    req_imm    = v.imm;
    req_valid  = 1'b1;
    @(negedge clock);
    req_valid  = 1'b0;
    req_src    = ~v.src;
    req_dst    = ~v.dst;
    req_imm_en = ~v.imm_en;
    req_imm    = ~v.imm;
    if (v.exp_err) begin
      chk("rej_err", err === 1'b1);
      chk("rej_done", done === 1'b0);
      chk("rej_strobes", {out_en, write_en, bus_oe} === 13'h0);
      chk("rej_ready", req_ready === 1'b1);
      chk("rej_last", last_data === v.exp_last);
      @(negedge clock);
      chk("rej_err_pulse", err === 1'b0);
    end else begin
      chk("drv_out_en", out_en === v.exp_out_en);
      chk("drv_bus_oe", bus_oe === v.imm_en);
      chk("drv_bus_out", bus_out === exp_bo);
      chk("drv_write_en", write_en === 6'h00);
      chk("drv_ready", req_ready === 1'b0);
      chk("drv_err", err === 1'b0);
      @(negedge clock);
      chk("wr_out_en", out_en === v.exp_out_en);
      chk("wr_bus_oe", bus_oe === v.imm_en);
      chk("wr_bus_out", bus_out === exp_bo);
      chk("wr_write_en", write_en === v.exp_we);
      chk("wr_done", done === 1'b0);
      @(negedge clock);
      chk("done_pulse", done === 1'b1);
      chk("done_ready", req_ready === 1'b1);
      chk("done_last", last_data === v.exp_last);
      chk("done_strobes", {out_en, write_en, bus_oe} === 13'h0);
      chk("done_reg", bank[v.dst] === v.exp_last);
      @(negedge clock);
      chk("done_one_cycle", done === 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0]    bb_imm [3];
    logic [NR-1:0] bb_we  [3];
    vec_t          post;

    //          src   dst   imm   imm    err   out_en  we     last
    vt[0] = '{3'd0, 3'd2, 1'b1, 8'hA5, 1'b0, 6'h00, 6'h04, 8'hA5};
    vt[1] = '{3'd2, 3'd5, 1'b0, 8'h00, 1'b0, 6'h04, 6'h20, 8'hA5};
    vt[2] = '{3'd0, 3'd0, 1'b1, 8'h3C, 1'b0, 6'h00, 6'h01, 8'h3C};
    vt[3] = '{3'd0, 3'd3, 1'b1, 8'h81, 1'b0, 6'h00, 6'h08, 8'h81};
    vt[4] = '{3'd3, 3'd3, 1'b0, 8'h00, 1'b0, 6'h08, 6'h08, 8'h81};
    vt[5] = '{3'd0, 3'd7, 1'b0, 8'h00, 1'b1, 6'h00, 6'h00, 8'h81};
    vt[6] = '{3'd6, 3'd1, 1'b1, 8'h5A, 1'b0, 6'h00, 6'h02, 8'h5A};
    vt[7] = '{3'd6, 3'd1, 1'b0, 8'h00, 1'b1, 6'h00, 6'h00, 8'h5A};
    vt[8] = '{3'd0, 3'd4, 1'b0, 8'h00, 1'b0, 6'h01, 6'h10, 8'h3C};

    reset_n    = 1'b0;
    req_valid  = 1'b0;
    req_src    = 3'd0;
    req_dst    = 3'd0;
    req_imm_en = 1'b0;
    req_imm    = 8'h00;

    #12;
    chk("rst_ready", req_ready === 1'b1);
    chk("rst_strobes", {out_en, write_en, bus_oe} === 13'h0);
    chk("rst_bus_out", bus_out === 8'h00);
    chk("rst_last", last_data === 8'h00);
    chk("rst_pulses", {done, err} === 2'b00);
    @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < 9; i++) do_xfer(vt[i]);

    // Back-to-back: valid held high, a new request presented in each done cycle.
    bb_imm = '{8'h11, 8'h22, 8'h33};
    bb_we  = '{6'h01, 6'h02, 6'h04};
    @(negedge clock);
    req_imm_en = 1'b1;
    req_imm    = bb_imm[0];
    req_dst    = 3'd0;
    req_valid  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk("b2b_drv_ready", req_ready === 1'b0);
      chk("b2b_drv_bus_out", bus_out === bb_imm[k]);
      chk("b2b_drv_we", write_en === 6'h00);
      req_imm = 8'hEE;
      req_dst = 3'd7;
      @(negedge clock);
      chk("b2b_wr_we", write_en === bb_we[k]);
      chk("b2b_wr_bus_out", bus_out === bb_imm[k]);
      chk("b2b_wr_err", err === 1'b0);
      @(negedge clock);
      chk("b2b_done", done === 1'b1);
      chk("b2b_ready", req_ready === 1'b1);
      chk("b2b_last", last_data === bb_imm[k]);
      if (k < 2) begin
        req_imm = bb_imm[k+1];
        req_dst = 3'(k + 1);
      end else begin
        req_valid = 1'b0;
      end
    end
    @(negedge clock);
    chk("b2b_idle", {done, req_ready} === 2'b01);
    chk("b2b_r0", bank[0] === 8'h11);
    chk("b2b_r1", bank[1] === 8'h22);
    chk("b2b_r2", bank[2] === 8'h33);

    // Reset asserted in the middle of the WRITE cycle.
    req_imm_en = 1'b1;
    req_imm    = 8'h77;
    req_dst    = 3'd5;
    req_valid  = 1'b1;
    @(negedge clock);
    req_valid = 1'b0;
    @(negedge clock);
    chk("rstw_we_before", write_en === 6'h20);
    #1 reset_n = 1'b0;
    #1;
    chk("rstw_strobes", {out_en, write_en, bus_oe} === 13'h0);
    chk("rstw_ready", req_ready === 1'b1);
    chk("rstw_done", done === 1'b0);
    @(posedge clock);
    #1;
    chk("rstw_r5_kept", bank[5] === 8'hA5);
    chk("rstw_last", last_data === 8'h00);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    chk("rstw_after_ready", req_ready === 1'b1);
    chk("rstw_after_strobes", {out_en, write_en, bus_oe, done, err} === 15'h0);

    post = '{3'd5, 3'd3, 1'b0, 8'h00, 1'b0, 6'h20, 6'h08, 8'hA5};
    do_xfer(post);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
